// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and stall sequencer for the 5-stage RISC-V pipeline. It drives the
//   stall/flush enables of the pipeline registers, the EX-stage forwarding
//   selects, and the data-memory req/ack handshake, which has a timeout guard.
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-high reset
//   rs1D/rs2D             ID-stage source registers
//   rs1E/rs2E/rdE         EX-stage sources / destination
//   memReadE, pcSrcE      EX load flag, EX taken branch/jump
//   rdM, regWriteM        MEM-stage destination / write enable
//   memReqM, memAckM      MEM data-memory request / completion
//   rdW, regWriteW        WB-stage destination / write enable
//   stallF..flushW        pipeline register hold/clear enables
//   forwardAE/forwardBE   operand selects: 00 regfile, 01 WB, 10 MEM
//   memReqOut             request valid to data memory
//   error                 sticky memory-timeout flag
//   stallCount            saturating count of cycles with stallF asserted
module pipeline_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic             memReadE,
  input  logic             pcSrcE,
  input  logic [4:0]       rdM,
  input  logic             regWriteM,
  input  logic             memReqM,
  input  logic             memAckM,
  input  logic [4:0]       rdW,
  input  logic             regWriteW,
  output logic             stallF,
  output logic             stallD,
  output logic             flushD,
  output logic             stallE,
  output logic             flushE,
  output logic             stallM,
  output logic             flushW,
  output logic [1:0]       forwardAE,
  output logic [1:0]       forwardBE,
  output logic             memReqOut,
  output logic             error,
  output logic [CNT_W-1:0] stallCount
);

  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {RUN, MEM_WAIT, ERROR} state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              memStall;
  logic              loadUse;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      wait_q     <= '0;
      error      <= 1'b0;
      stallCount <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      error   <= error | (state_d == ERROR);
      if (stallF && (stallCount != '1))
        stallCount <= stallCount + 1'b1;
    end
  end

  // Counter holds the number of stalled waiting cycles so far; the RUN cycle
  // that issues the request counts as the first, so ERROR is entered once
  // the count would reach TIMEOUT without an ack.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    unique case (state_q)
      RUN: begin
        if (memReqM && !memAckM) begin
          state_d = MEM_WAIT;
          wait_d  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (memAckM) begin
          state_d = RUN;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_q >= WAIT_W'(TIMEOUT - 1))
            state_d = ERROR;
        end
      end
      default: state_d = ERROR;
    endcase
  end

  assign memStall = ((state_q == RUN) && memReqM && !memAckM) ||
                    ((state_q == MEM_WAIT) && !memAckM) ||
                    (state_q == ERROR);

  assign loadUse = memReadE && (rdE != 5'd0) && ((rdE == rs1D) || (rdE == rs2D));

  always_comb begin
    stallF    = 1'b0;
    stallD    = 1'b0;
    flushD    = 1'b0;
    stallE    = 1'b0;
    flushE    = 1'b0;
    stallM    = 1'b0;
    flushW    = 1'b0;
    memReqOut = 1'b0;
    if (memStall) begin
      stallF = 1'b1;
      stallD = 1'b1;
      stallE = 1'b1;
      stallM = 1'b1;
      flushW = 1'b1;
    end else if (pcSrcE) begin
      flushD = 1'b1;
      flushE = 1'b1;
    end else if (loadUse) begin
      stallF = 1'b1;
      stallD = 1'b1;
      flushE = 1'b1;
    end
    unique case (state_q)
      RUN:      memReqOut = memReqM;
      MEM_WAIT: memReqOut = 1'b1;
      default:  memReqOut = 1'b0;
    endcase
  end

  always_comb begin
    forwardAE = 2'b00;
    forwardBE = 2'b00;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs1E))
      forwardAE = 2'b10;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs1E))
      forwardAE = 2'b01;
    if (regWriteM && (rdM != 5'd0) && (rdM == rs2E))
      forwardBE = 2'b10;
    else if (regWriteW && (rdW != 5'd0) && (rdW == rs2E))
      forwardBE = 2'b01;
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl (TIMEOUT=4, CNT_W=4).
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] rs1D = '0, rs2D = '0, rs1E = '0, rs2E = '0, rdE = '0, rdM = '0, rdW = '0;
  logic       memReadE = 1'b0, pcSrcE = 1'b0, regWriteM = 1'b0, regWriteW = 1'b0;
  logic       memReqM = 1'b0, memAckM = 1'b0;
  logic       stallF, stallD, flushD, stallE, flushE, stallM, flushW, memReqOut, error;
  logic [1:0] forwardAE, forwardBE;
  logic [3:0] stallCount;

  pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .memReadE(memReadE), .pcSrcE(pcSrcE), .rdM(rdM), .regWriteM(regWriteM),
    .memReqM(memReqM), .memAckM(memAckM), .rdW(rdW), .regWriteW(regWriteW),
    .stallF(stallF), .stallD(stallD), .flushD(flushD), .stallE(stallE),
    .flushE(flushE), .stallM(stallM), .flushW(flushW),
    .forwardAE(forwardAE), .forwardBE(forwardBE), .memReqOut(memReqOut),
    .error(error), .stallCount(stallCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic       memReadE, pcSrcE, regWriteM, regWriteW, memReqM, memAckM;
  } in_t;

  typedef struct {
    string       nm;
    logic [11:0] e;
  } exp_t;

  typedef struct {
    in_t         v;
    logic [11:0] e;
    string       nm;
  } vec_t;

  exp_t       sb[$];
  vec_t       tbl[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [3:0] mcnt  = '0;

  // Expected-output word: {stallF,stallD,flushD,stallE,flushE,stallM,flushW,fwdA,fwdB,memReqOut}
  function automatic logic [11:0] E(input logic sF, sD, fD, sE, fE, sM, fW,
                                    input logic [1:0] fa, fb, input logic mro);
    return {sF, sD, fD, sE, fE, sM, fW, fa, fb, mro};
  endfunction

  task automatic drive(input in_t v);
    rst = v.rst; rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW; memReadE = v.memReadE; pcSrcE = v.pcSrcE;
    regWriteM = v.regWriteM; regWriteW = v.regWriteW; memReqM = v.memReqM; memAckM = v.memAckM;
  endtask

  // Drive one cycle of stimulus, queue its expectation, then check the
  // combinational outputs mid-cycle.
  task automatic step(input in_t v, input logic [11:0] e, input string nm);
    exp_t        r;
    logic [11:0] act;
    @(negedge clk);
    drive(v);
    sb.push_back('{nm: nm, e: e});
    #2;
    r   = sb.pop_front();
    act = {stallF, stallD, flushD, stallE, flushE, stallM, flushW, forwardAE, forwardBE, memReqOut};
    n_cmp++;
    if (act !== r.e) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", r.nm, act, r.e);
    end
    if (v.rst) mcnt = '0;
    else if (e[11] && mcnt != 4'hF) mcnt = mcnt + 4'd1;
  endtask

  task automatic chk_reg(input string nm, input logic exp_err);
    @(posedge clk);
    #1;
    n_cmp++;
    if (error !== exp_err || stallCount !== mcnt) begin
      n_bad++;
      $display("FAIL %s: got error=%b cnt=%0d want error=%b cnt=%0d",
               nm, error, stallCount, exp_err, mcnt);
    end
  endtask

  task automatic do_reset(input string nm);
    in_t z;
    z = '0;
    z.rst = 1'b1;
    @(negedge clk);
    drive(z);
    mcnt = '0;
    #2;
    n_cmp++;
    if (error !== 1'b0 || stallCount !== 4'd0 || stallF !== 1'b0 || memReqOut !== 1'b0) begin
      n_bad++;
      $display("FAIL %s: got error=%b cnt=%0d stallF=%b mro=%b want all 0",
               nm, error, stallCount, stallF, memReqOut);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic add(input in_t v, input logic [11:0] e, input string nm);
    tbl.push_back('{v: v, e: e, nm: nm});
  endtask

  initial begin : watchdog
    #20000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    in_t         v;
    logic [11:0] LU, BR, ST, ST_ERR;
    LU = E(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 0);
    BR = E(0, 0, 1, 0, 1, 0, 0, 2'b00, 2'b00, 0);

    do_reset("reset_initial");

    // Single-cycle RUN vectors
    v = '0;                                                      add(v, '0, "idle");
    v = '0; v.memReadE = 1; v.rdE = 5; v.rs1D = 5;              add(v, LU, "lu_rs1");
    v = '0; v.memReadE = 1; v.rdE = 0; v.rs1D = 0;              add(v, '0, "lu_rd0");
    v = '0; v.memReadE = 1; v.rdE = 9; v.rs2D = 9; v.rs1D = 4;  add(v, LU, "lu_rs2");
    v = '0; v.rdE = 9; v.rs1D = 9;                              add(v, '0, "no_load");
    v = '0; v.regWriteM = 1; v.rdM = 7; v.regWriteW = 1; v.rdW = 7; v.rs1E = 7; v.rs2E = 3;
    add(v, E(0, 0, 0, 0, 0, 0, 0, 2'b10, 2'b00, 0), "fwd_m_prio");
    v.rdM = 0;
    add(v, E(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 0), "fwd_w");
    v = '0; v.rdM = 3; v.regWriteW = 1; v.rdW = 3; v.rs1E = 3; v.rs2E = 3;
    add(v, E(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 0), "fwd_m_nowrite");
    v = '0; v.regWriteM = 1; v.rdM = 3; v.regWriteW = 1; v.rdW = 3; v.rs1E = 1; v.rs2E = 3;
    add(v, E(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 0), "fwd_b_m");
    v = '0; v.regWriteM = 1; v.regWriteW = 1;                   add(v, '0, "fwd_x0");
    v = '0; v.pcSrcE = 1;                                       add(v, BR, "branch");
    v = '0; v.pcSrcE = 1; v.memReadE = 1; v.rdE = 5; v.rs1D = 5; add(v, BR, "branch_over_lu");
    v = '0; v.memReqM = 1; v.memAckM = 1;
    add(v, E(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 1), "mem_hit");
    v.memReadE = 1; v.rdE = 6; v.rs2D = 6;
    add(v, E(1, 1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1), "mem_hit_lu");

    foreach (tbl[i]) step(tbl[i].v, tbl[i].e, tbl[i].nm);
    chk_reg("cnt_after_table", 1'b0);

    // Multi-cycle memory wait; branch and load-use suppressed until the ack
    v = '0; v.memReqM = 1; v.pcSrcE = 1; v.memReadE = 1; v.rdE = 5; v.rs1D = 5;
    v.regWriteM = 1; v.rdM = 7; v.rs1E = 7;
    ST = E(1, 1, 0, 1, 0, 1, 1, 2'b10, 2'b00, 1);
    step(v, ST, "wait_c1");
    step(v, ST, "wait_c2");
    chk_reg("wait_mid_reg", 1'b0);
    v.memReqM = 0;
    step(v, ST, "wait_c3");
    v.memAckM = 1;
    step(v, E(0, 0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 1), "wait_ack_branch");
    v = '0;
    step(v, '0, "back_to_run");
    chk_reg("cnt_after_wait", 1'b0);

    // Timeout into ERROR, then saturation of the stall counter
    do_reset("reset_before_timeout");
    v = '0; v.memReqM = 1;
    ST = E(1, 1, 0, 1, 0, 1, 1, 2'b00, 2'b00, 1);
    for (int unsigned i = 0; i < 4; i++) begin
      step(v, ST, "timeout_wait");
      chk_reg("timeout_err", (i == 3) ? 1'b1 : 1'b0);
    end
    v.regWriteW = 1; v.rdW = 2; v.rs2E = 2;
    ST_ERR = E(1, 1, 0, 1, 0, 1, 1, 2'b00, 2'b01, 0);
    for (int unsigned i = 0; i < 16; i++) begin
      v.memAckM = i[0];
      step(v, ST_ERR, "error_hold");
    end
    chk_reg("saturate", 1'b1);
    do_reset("reset_from_error");

    // Reset while in MEM_WAIT drops the pending request
    v = '0; v.memReqM = 1;
    step(v, ST, "mw_a");
    step(v, ST, "mw_b");
    v = '0; v.rst = 1;
    step(v, '0, "reset_mid_wait");
    chk_reg("reset_mid_wait_reg", 1'b0);
    v = '0;
    step(v, '0, "after_reset_idle");
    chk_reg("after_reset_reg", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and stall sequencer for the 5-stage RISC-V pipeline. It drives the stall/flush enables of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and the EX-stage forwarding selects. It also sequences multi-cycle data-memory accesses through a req/ack handshake, including a timeout guard. It sits beside the datapath and takes stage register fields as inputs.

Parameters:
TIMEOUT, 64, max cycles waiting for memAckM before entering ERROR (≥2)
CNT_W, 16, width of saturating stall-cycle performance counter

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset
rs1D  input  5  ID-stage source register 1
rs2D  input  5  ID-stage source register 2
rs1E  input  5  EX-stage source register 1
rs2E  input  5  EX-stage source register 2
rdE  input  5  EX-stage destination
memReadE  input  1  EX instruction is a load
pcSrcE  input  1  EX-stage taken branch/jump
rdM  input  5  MEM-stage destination
regWriteM  input  1  MEM-stage writes register file
memReqM  input  1  MEM instruction accesses data memory
memAckM  input  1  data memory completes access this cycle
rdW  input  5  WB-stage destination
regWriteW  input  1  WB-stage writes register file
stallF  output  1  hold PC
stallD  output  1  hold IF/ID
flushD  output  1  clear IF/ID
stallE  output  1  hold ID/EX
flushE  output  1  clear ID/EX
stallM  output  1  hold EX/MEM
flushW  output  1  load bubble into MEM/WB
forwardAE  output  2  operand A select: 00 regfile, 01 WB result, 10 MEM ALU result
forwardBE  output  2  operand B select, same encoding
memReqOut  output  1  request valid to data memory
error  output  1  sticky memory timeout flag
stallCount  output  CNT_W  cycles with stallF asserted, saturating

Behaviour:
- Reset is asynchronous and active-high on rst; the block is clocked on clk. Reset forces: state=RUN, wait counter=0, error=0, stallCount=0.
- With reset asserted, all stall/flush outputs are 0 unless a combinational term below asserts them. memReqOut follows memReqM. forwardAE/BE follow the forwarding rule.
- States: RUN, MEM_WAIT, ERROR. State, wait counter, error and stallCount are registered. All other outputs are combinational from state and inputs.
- memStall = (RUN & memReqM & ~memAckM) | (MEM_WAIT & ~memAckM) | ERROR.
- While memStall: stallF=stallD=stallE=stallM=1, flushW=1, flushD=flushE=0. Load-use and branch terms are suppressed; the EX branch re-presents after release.
- RUN transitions:
  - memReqM & ~memAckM → MEM_WAIT, wait counter=1.
  - memReqM & memAckM in the same cycle = single-cycle hit: no stall, stay RUN.
- MEM_WAIT transitions:
  - memAckM → RUN. In the ack cycle memStall=0 and the pipeline advances.
  - Otherwise the wait counter increments. When the counter reaches TIMEOUT with no ack → ERROR.
- ERROR: absorbing until reset; error=1 and all stalls held.
- memReqOut = memReqM in RUN; 1 in MEM_WAIT; 0 in ERROR.
- Load-use hazard (RUN, no memStall): memReadE & rdE≠0 & (rdE==rs1D | rdE==rs2D) → stallF=1, stallD=1, flushE=1.
- Branch (RUN, no memStall): pcSrcE → flushD=1, flushE=1.
- Branch has priority over load-use: on a simultaneous branch and load-use, stallF=stallD=0 and flushD=flushE=1.
- Forwarding for operand A (B identical using rs2E):
  - 10 if regWriteM & rdM≠0 & rdM==rs1E;
  - else 01 if regWriteW & rdW≠0 & rdW==rs1E;
  - else 00.
  - Forwarding is evaluated in every state.
- stallCount increments each cycle stallF=1, saturates at all-ones, and is never cleared except by reset.
- Reset mid-MEM_WAIT: returns to RUN immediately, and the pending request is dropped.

Test Plan:
- Load-use: memReadE=1, rdE=5, rs1D=5, no mem activity → stallF=stallD=flushE=1 for that cycle; stallCount increments by 1. Repeat with rdE=0 → no stall.
- Forwarding: regWriteM=1, rdM=7, regWriteW=1, rdW=7, rs1E=7, rs2E=3 → forwardAE=10, forwardBE=00. Set rdM=0 → forwardAE=01.
- Memory wait: memReqM=1, ack asserted on the 4th cycle → stalls and flushW high for 3 cycles, state RUN after ack, memReqOut high throughout; single-cycle ack → zero stalls.
- Branch vs load-use simultaneous: pcSrcE=1 plus a load-use match → flushD=flushE=1, stallF=stallD=0. Branch during MEM_WAIT → no flush until ack.
- Timeout: TIMEOUT=4, memReqM=1, never ack → error=1 after 4 waiting cycles, stalls stuck. Assert rst → error=0, state RUN, stallCount=0.
- Saturation: CNT_W=4, hold a memory stall for 20 cycles → stallCount=15.
